// File: rtl/bcd_count4_if.sv
// Control/status bundle between the board switches and the four-digit BCD counter.
// The master side drives the controls and load value; the slave side is the counter.
interface bcd_count4_if;
   logic        Run;
   logic        Clear;
   logic        Load;
   logic [15:0] LoadVal;
   logic        Up;
   logic [15:0] Count;
   logic        Tick;
   logic        Wrap;

   modport master (
      output Run, Clear, Load, LoadVal, Up,
      input  Count, Tick, Wrap
   );

   modport slave (
      input  Run, Clear, Load, LoadVal, Up,
      output Count, Tick, Wrap
   );
endinterface

// File: rtl/bcd_count4.sv
// Four-digit packed-BCD counter with prescaler, run/hold, clear and saturating load.
// Define BCD_COUNT_DOWN_EN to compile in down-counting selected by Up.
module bcd_count4 #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic          Clock,
   input  logic          Resetn,
   bcd_count4_if.slave   bus
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_TERM = PW'(TICK_DIV - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [15:0]   count_q, count_d;
   logic          tick_q, tick_d;
   logic          wrap_q, wrap_d;
   logic [16:0]   step_s;

   // Returns {wrap, next} for a ripple-carry BCD increment.
   function automatic logic [16:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = 16'h0000;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (v[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
               c           = 1'b1;
            end else begin
               r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
               c           = 1'b0;
            end
         end else begin
            r[i*4 +: 4] = v[i*4 +: 4];
         end
      end
      return {c, r};
   endfunction

`ifdef BCD_COUNT_DOWN_EN
   // Returns {wrap, next} for a ripple-borrow BCD decrement.
   function automatic logic [16:0] bcd_dec(input logic [15:0] v);
      logic [15:0] r;
      logic        b;
      r = 16'h0000;
      b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (b) begin
            if (v[i*4 +: 4] == 4'd0) begin
               r[i*4 +: 4] = 4'd9;
               b           = 1'b1;
            end else begin
               r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
               b           = 1'b0;
            end
         end else begin
            r[i*4 +: 4] = v[i*4 +: 4];
         end
      end
      return {b, r};
   endfunction
`endif

   function automatic logic [15:0] bcd_sat(input logic [15:0] v);
      logic [15:0] r;
      r = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         if (v[i*4 +: 4] > 4'd9) begin
            r[i*4 +: 4] = 4'd9;
         end else begin
            r[i*4 +: 4] = v[i*4 +: 4];
         end
      end
      return r;
   endfunction

`ifdef BCD_COUNT_DOWN_EN
   assign step_s = bus.Up ? bcd_inc(count_q) : bcd_dec(count_q);
`else
   logic unused_up_s;
   assign unused_up_s = bus.Up;
   assign step_s      = bcd_inc(count_q);
`endif

   // Clear beats Load beats a prescaler-driven step.
   always_comb begin
      presc_d = presc_q;
      count_d = count_q;
      tick_d  = 1'b0;
      wrap_d  = 1'b0;
      if (bus.Clear) begin
         presc_d = PW'(0);
         count_d = 16'h0000;
      end else if (bus.Load) begin
         presc_d = PW'(0);
         count_d = bcd_sat(bus.LoadVal);
      end else if (bus.Run) begin
         if (presc_q == PRESC_TERM) begin
            presc_d = PW'(0);
            count_d = step_s[15:0];
            tick_d  = 1'b1;
            wrap_d  = step_s[16];
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end else begin
         presc_d = presc_q;
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         presc_q <= PW'(0);
         count_q <= 16'h0000;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         count_q <= count_d;
         tick_q  <= tick_d;
         wrap_q  <= wrap_d;
      end
   end

   assign bus.Count = count_q;
   assign bus.Tick  = tick_q;
   assign bus.Wrap  = wrap_q;

endmodule

// File: tb/tb_bcd_count4.sv
// Directed self-checking bench for bcd_count4 with TICK_DIV = 4.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on rising edges.
module tb_bcd_count4;

   logic Clock;
   logic Resetn;
   int   checks;
   int   errors;
   int   ticks;

   bcd_count4_if bus ();

   bcd_count4 #(.TICK_DIV(4)) dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .bus    (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge Clock);
   endtask

   task automatic do_load(input logic [15:0] v);
      bus.LoadVal = v;
      bus.Load    = 1'b1;
      cyc(1);
      bus.Load    = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      Resetn      = 1'b0;
      bus.Run     = 1'b0;
      bus.Clear   = 1'b0;
      bus.Load    = 1'b0;
      bus.LoadVal = 16'h0000;
      bus.Up      = 1'b1;
      cyc(2);
      chk("rst_count", bus.Count, 16'h0000);
      chk("rst_tick", {15'd0, bus.Tick}, 16'd0);
      chk("rst_wrap", {15'd0, bus.Wrap}, 16'd0);

      // First step lands on the 4th edge after release.
      Resetn  = 1'b1;
      bus.Run = 1'b1;
      cyc(3);
      chk("pre_first_tick", {15'd0, bus.Tick}, 16'd0);
      chk("pre_first_count", bus.Count, 16'h0000);
      cyc(1);
      chk("first_tick", {15'd0, bus.Tick}, 16'd1);
      chk("first_count", bus.Count, 16'h0001);
      cyc(1);
      chk("tick_one_cycle", {15'd0, bus.Tick}, 16'd0);

      // Asynchronous reset mid-interval.
      do_load(16'h0042);
      chk("load_0042", bus.Count, 16'h0042);
      cyc(2);
      #2 Resetn = 1'b0;
      #1;
      chk("async_rst_count", bus.Count, 16'h0000);
      chk("async_rst_tick", {15'd0, bus.Tick}, 16'd0);
      cyc(1);
      Resetn = 1'b1;

      // Carries.
      do_load(16'h0099);
      chk("load_0099", bus.Count, 16'h0099);
      cyc(3);
      chk("carry_pre", bus.Count, 16'h0099);
      cyc(1);
      chk("carry_0100", bus.Count, 16'h0100);
      chk("carry_tick", {15'd0, bus.Tick}, 16'd1);
      ticks = 0;
      for (int i = 0; i < 8; i++) begin
         cyc(1);
         if (bus.Tick === 1'b1) ticks++;
      end
      chk("tick_rate", 16'(ticks), 16'd2);
      chk("count_0102", bus.Count, 16'h0102);

      do_load(16'h0999);
      cyc(4);
      chk("carry_1000", bus.Count, 16'h1000);
      chk("carry_1000_wrap", {15'd0, bus.Wrap}, 16'd0);

      // Up wrap.
      do_load(16'h9999);
      cyc(4);
      chk("wrap_count", bus.Count, 16'h0000);
      chk("wrap_pulse", {15'd0, bus.Wrap}, 16'd1);
      chk("wrap_tick", {15'd0, bus.Tick}, 16'd1);
      cyc(1);
      chk("wrap_one_cycle", {15'd0, bus.Wrap}, 16'd0);
      chk("wrap_tick_one_cycle", {15'd0, bus.Tick}, 16'd0);

      // Load saturation and priority.
      do_load(16'hFFFF);
      chk("sat_ffff", bus.Count, 16'h9999);
      do_load(16'h3AF7);
      chk("sat_3af7", bus.Count, 16'h3997);
      bus.Clear = 1'b1;
      do_load(16'h1234);
      bus.Clear = 1'b0;
      chk("clear_over_load", bus.Count, 16'h0000);
      cyc(3);
      do_load(16'h5678);
      chk("load_at_term", bus.Count, 16'h5678);
      chk("load_at_term_tick", {15'd0, bus.Tick}, 16'd0);

      // Hold keeps the partial prescale.
      cyc(2);
      bus.Run = 1'b0;
      ticks = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         if (bus.Tick === 1'b1) ticks++;
      end
      chk("hold_no_tick", 16'(ticks), 16'd0);
      chk("hold_count", bus.Count, 16'h5678);
      bus.Run = 1'b1;
      cyc(1);
      chk("resume_pre", {15'd0, bus.Tick}, 16'd0);
      cyc(1);
      chk("resume_tick", {15'd0, bus.Tick}, 16'd1);
      chk("resume_count", bus.Count, 16'h5679);

      // Direction.
      bus.Up = 1'b0;
`ifdef BCD_COUNT_DOWN_EN
      do_load(16'h1000);
      cyc(4);
      chk("down_0999", bus.Count, 16'h0999);
      chk("down_nowrap", {15'd0, bus.Wrap}, 16'd0);
      do_load(16'h0000);
      cyc(4);
      chk("down_wrap_count", bus.Count, 16'h9999);
      chk("down_wrap", {15'd0, bus.Wrap}, 16'd1);
`else
      do_load(16'h1000);
      cyc(4);
      chk("updown_ignored", bus.Count, 16'h1001);
      do_load(16'h9999);
      cyc(4);
      chk("updown_wrap_count", bus.Count, 16'h0000);
      chk("updown_wrap", {15'd0, bus.Wrap}, 16'd1);
`endif
      bus.Up = 1'b1;

      // Clear applies while held.
      do_load(16'h4321);
      bus.Run   = 1'b0;
      bus.Clear = 1'b1;
      cyc(1);
      bus.Clear = 1'b0;
      chk("clear_held", bus.Count, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_count4.md
# bcd_count4

Four-digit synchronous BCD counter that produces the 16-bit packed-BCD value driven onto the four seven-segment digits.
- Sits directly upstream of the four `HexDisplay` decoders: `Count[3:0]` feeds HEX0, and so on up to `Count[15:12]` feeding HEX3.
- An internal prescaler turns the fast board clock into a slow count tick.
- Supports run/hold, synchronous clear, and parallel load from the toggle switches.
- Optionally counts down.

## Interface
- `TICK_DIV`, default 50_000_000: `Clock` cycles per count step (1 Hz at 50 MHz). Legal range is ≥ 2.
- `Clock`  input  1  rising-edge system clock.
- `Resetn`  input  1  reset, asynchronous and active-low.
- `Run`  input  1  level; 1 lets the prescaler advance, 0 holds the prescaler and `Count`.
- `Clear`  input  1  synchronous; zeroes `Count` and the prescaler.
- `Load`  input  1  synchronous; loads `LoadVal` into `Count` and zeroes the prescaler.
- `LoadVal`  input  16  four BCD nibbles, normally taken from `SW[15:0]`.
- `Up`  input  1  direction, 1 = up, 0 = down. Used only when `BCD_COUNT_DOWN_EN` is defined.
- `Count`  output  16  packed BCD; each nibble is always in 0–9.
- `Tick`  output  1  one-cycle pulse, coincident with every `Count` step.
- `Wrap`  output  1  one-cycle pulse, coincident with a 9999→0000 or 0000→9999 step.

## Operation
- **Reset (`Resetn` = 0):**
  - `Count` = 16'h0000, `Tick` = 0, `Wrap` = 0, prescaler = 0.
  - Takes effect immediately, regardless of `Clock`, including mid-count.
- **Per-edge priority:** `Clear` > `Load` > count step.
- **Clear:**
  - `Count` ← 0000, prescaler ← 0, `Tick`/`Wrap` ← 0.
  - Applies regardless of `Run`.
- **Load:**
  - Each nibble of `LoadVal` is loaded into `Count`; any nibble above 9 saturates to 9. Example: `LoadVal` 16'h3AF7 loads 0x3997.
  - Prescaler ← 0, `Tick`/`Wrap` ← 0.
- **Prescaler:**
  - 0 … TICK_DIV−1 counter, sized ceil(log2(TICK_DIV)) bits.
  - Increments on each edge with `Run` = 1.
  - On the edge where it equals TICK_DIV−1 with `Run` = 1, it returns to 0 and a count step occurs.
- **Count step, up:**
  - Digit 0 increments.
  - A digit at 9 becomes 0 and carries into the next digit.
  - 9999 → 0000 with `Wrap` = 1.
- **Count step, down:**
  - Digit 0 decrements.
  - A digit at 0 becomes 9 and borrows from the next digit.
  - 0000 → 9999 with `Wrap` = 1.
- **Outputs:**
  - `Count`, `Tick` and `Wrap` are all registered; there are no combinational paths from inputs to outputs.
  - `Tick` is 1 only in the cycle after a step edge.
- **Hold (`Run` = 0):** prescaler and `Count` freeze; `Tick` = `Wrap` = 0. Deasserting `Run` mid-interval does not lose the partial prescale.

## Timing
- **Step interval:** with `Run` held at 1 from prescaler = 0, the first step lands on the TICK_DIV-th rising edge; subsequent steps follow every TICK_DIV edges.
- **Update latency:** the new `Count` value is visible in the cycle after the step edge, together with `Tick`, and `Wrap` when applicable.
- **Clear/Load latency:** one edge; the result is visible the next cycle.
- **Simultaneous `Load` and prescaler terminal count:** `Load` wins, no step occurs, and `Tick` = 0.
- **`Resetn` release:** synchronized externally; the block requires release at least one `Clock` setup time before an edge.
- **Debouncing:** `Run`, `Clear` and `Load` are treated as synchronous, already-debounced levels; debouncing is upstream.

## Configuration
- **`BCD_COUNT_DOWN_EN` defined:**
  - `Up` selects the counting direction.
  - Down-count and borrow logic are compiled in.
- **`BCD_COUNT_DOWN_EN` not defined:**
  - The `Up` port stays in the interface but is ignored.
  - The counter is up-only, and no down/borrow logic is synthesized.

## Test plan
All scenarios use `TICK_DIV` = 4.
- **Reset:** assert `Resetn` = 0 asynchronously mid-interval at `Count` = 0042 → `Count` = 0000 and `Tick` = `Wrap` = 0 immediately. After release with `Run` = 1, the first `Tick` comes 4 edges later with `Count` = 0001.
- **Digit carries:**
  - Load 0099, `Run` = 1 → after one step, `Count` = 0100.
  - Load 0999 → 1000.
  - `Tick` pulses exactly once per 4 cycles.
- **Up wrap:** load 9999, `Run` = 1 → the step yields `Count` = 0000 with `Wrap` = 1 and `Tick` = 1, both for one cycle only.
- **Load saturation and priority:**
  - `LoadVal` = FFFF → `Count` = 9999.
  - Assert `Clear` and `Load` together → `Count` = 0000.
  - Assert `Load` on the terminal-count edge → `Count` = `LoadVal`, no `Tick`.
- **Hold:** with `Run` = 1, drop `Run` after 2 prescale cycles for 10 cycles, then reassert → `Count` unchanged while held. The next step occurs 2 cycles after reassertion.
- **Down-count and wrap (`BCD_COUNT_DOWN_EN` defined):**
  - With `Up` = 0: 1000 → 0999; 0000 → 9999 with `Wrap` = 1.
  - With the macro undefined: `Up` = 0 still counts up.
